// File: rtl/reg_f_arb_pkg.sv
// Shared types and constants for the reg_f access arbiter.
package reg_f_arb_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Requester identifiers, also used as bit positions in the request/grant vectors
  localparam logic REQ_ID_A = 1'b0;
  localparam logic REQ_ID_B = 1'b1;

  // Select width for a register file of 'size' entries
  function automatic int sel_width(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: grants the sole requester, or the priority
// holder when both request; the next priority goes to the loser.
module rr_arb2
  import reg_f_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       pri_i,
  input  logic       update_i,
  output logic [1:0] gnt_o,
  output logic       pri_nxt_o
);

  // One-hot grant and next priority pointer
  always_comb begin
    gnt_o     = req_i;
    pri_nxt_o = pri_i;
    if (req_i == 2'b11) begin
      gnt_o = (pri_i == REQ_ID_B) ? 2'b10 : 2'b01;
    end
    if (update_i && (|req_i)) begin
      pri_nxt_o = gnt_o[REQ_ID_A] ? REQ_ID_B : REQ_ID_A;
    end
  end

endmodule

// File: rtl/reg_f_arb.sv
// Round-robin arbiter and access sequencer for the single-port reg_f.
// Writes to the port address (select all ones) keep RF_EN asserted for
// PORT_HOLD extra cycles so the external port sees a stretched strobe.
module reg_f_arb
  import reg_f_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIZE      = 9,
  parameter int PORT_HOLD = 2,
  localparam int SEL_W    = sel_width(SIZE)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_A,
  input  logic             WE_A,
  input  logic [SEL_W-1:0] SEL_A,
  input  logic [WIDTH-1:0] DATA_A,
  output logic             GNT_A,
  output logic             RVALID_A,
  output logic [WIDTH-1:0] RDATA_A,
  input  logic             REQ_B,
  input  logic             WE_B,
  input  logic [SEL_W-1:0] SEL_B,
  input  logic [WIDTH-1:0] DATA_B,
  output logic             GNT_B,
  output logic             RVALID_B,
  output logic [WIDTH-1:0] RDATA_B,
  output logic             RF_EN,
  output logic [SEL_W-1:0] RF_SEL,
  output logic [WIDTH-1:0] RF_IN,
  input  logic [WIDTH-1:0] RF_OUT,
  output logic             BUSY,
  output logic             ERR
);

  localparam logic [SEL_W-1:0] PORT_SEL = '1;
  localparam int               CNT_W    = (PORT_HOLD > 1) ? $clog2(PORT_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = (PORT_HOLD > 0) ? CNT_W'(PORT_HOLD - 1) : '0;

  state_e           state_q, state_d;
  logic             pri_q, pri_d;
  logic             win_q, win_d;
  logic             we_q, we_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [WIDTH-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;

  logic [1:0]       arb_req, arb_gnt;
  logic             arb_pri_nxt;
  logic             take;
  logic             illegal;
  logic             hold_go;

  // Out-of-range select that is not the port address
  assign illegal = (32'(sel_q) >= 32'(SIZE)) && (sel_q != PORT_SEL);
  // A legal port write enters the stretch phase (when stretching is enabled)
  assign hold_go = we_q && !illegal && (sel_q == PORT_SEL) && (PORT_HOLD > 0);
  assign take    = |arb_req;

  assign RF_SEL   = sel_q;
  assign RF_IN    = data_q;
  assign BUSY     = (state_q != IDLE);
  assign RVALID_A = rvalid_a_q;
  assign RVALID_B = rvalid_b_q;
  assign RDATA_A  = rdata_a_q;
  assign RDATA_B  = rdata_b_q;

  // Requests eligible for the next capture: anyone from IDLE, only the
  // non-winner back-to-back from ACCESS, nobody during HOLD
  always_comb begin
    arb_req = 2'b00;
    case (state_q)
      IDLE:    arb_req = {REQ_B, REQ_A};
      ACCESS:  if (!hold_go) arb_req = (win_q == REQ_ID_B) ? {1'b0, REQ_A} : {REQ_B, 1'b0};
      default: arb_req = 2'b00;
    endcase
  end

  rr_arb2 u_arb (
    .req_i     (arb_req),
    .pri_i     (pri_q),
    .update_i  (take),
    .gnt_o     (arb_gnt),
    .pri_nxt_o (arb_pri_nxt)
  );

  // Next-state, capture and file-strobe decode
  always_comb begin
    state_d    = state_q;
    pri_d      = arb_pri_nxt;
    win_d      = win_q;
    we_d       = we_q;
    sel_d      = sel_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    RF_EN      = 1'b0;
    GNT_A      = 1'b0;
    GNT_B      = 1'b0;
    ERR        = 1'b0;
    case (state_q)
      IDLE: begin
        if (take) state_d = ACCESS;
      end
      ACCESS: begin
        GNT_A = (win_q == REQ_ID_A);
        GNT_B = (win_q == REQ_ID_B);
        RF_EN = we_q && !illegal;
        ERR   = illegal;
        if (!we_q) begin
          if (win_q == REQ_ID_A) begin
            rvalid_a_d = 1'b1;
            rdata_a_d  = illegal ? '0 : RF_OUT;
          end else begin
            rvalid_b_d = 1'b1;
            rdata_b_d  = illegal ? '0 : RF_OUT;
          end
        end
        if (hold_go) begin
          state_d = HOLD;
          cnt_d   = CNT_LOAD;
        end else if (take) begin
          state_d = ACCESS;
        end else begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        RF_EN = 1'b1;
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      win_d  = arb_gnt[REQ_ID_B];
      we_d   = arb_gnt[REQ_ID_A] ? WE_A   : WE_B;
      sel_d  = arb_gnt[REQ_ID_A] ? SEL_A  : SEL_B;
      data_d = arb_gnt[REQ_ID_A] ? DATA_A : DATA_B;
    end
  end

  // FSM state register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Captured request fields, priority pointer, stretch counter and read returns
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pri_q      <= REQ_ID_A;
      win_q      <= REQ_ID_A;
      we_q       <= 1'b0;
      sel_q      <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
    end else begin
      pri_q      <= pri_d;
      win_q      <= win_d;
      we_q       <= we_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
    end
  end

endmodule

// File: tb/tb_reg_f_arb.sv
// Directed bench for reg_f_arb with a behavioural register file on RF_*.
module tb_reg_f_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [3:0] sel_a = '0, sel_b = '0;
  logic [7:0] data_a = '0, data_b = '0;
  logic       gnt_a, gnt_b, rvalid_a, rvalid_b, rf_en, busy, err;
  logic [7:0] rdata_a, rdata_b, rf_in, rf_out;
  logic [3:0] rf_sel;
  logic       mem_init = 1'b1;
  logic [7:0] mem [0:15];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  reg_f_arb #(.WIDTH(8), .SIZE(9), .PORT_HOLD(2)) dut (
    .CLK(clk), .RST(rst),
    .REQ_A(req_a), .WE_A(we_a), .SEL_A(sel_a), .DATA_A(data_a),
    .GNT_A(gnt_a), .RVALID_A(rvalid_a), .RDATA_A(rdata_a),
    .REQ_B(req_b), .WE_B(we_b), .SEL_B(sel_b), .DATA_B(data_b),
    .GNT_B(gnt_b), .RVALID_B(rvalid_b), .RDATA_B(rdata_b),
    .RF_EN(rf_en), .RF_SEL(rf_sel), .RF_IN(rf_in), .RF_OUT(rf_out),
    .BUSY(busy), .ERR(err)
  );

  // Register file model: combinational read, write on the clock edge
  assign rf_out = mem[rf_sel];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hEE;
      mem[15] <= 8'h3C;
    end else if (rf_en) begin
      mem[rf_sel] <= rf_in;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic r, input logic w, input logic [3:0] s, input logic [7:0] d);
    req_a = r; we_a = w; sel_a = s; data_a = d;
  endtask

  task automatic drive_b(input logic r, input logic w, input logic [3:0] s, input logic [7:0] d);
    req_b = r; we_b = w; sel_b = s; data_b = d;
  endtask

  typedef struct packed {
    logic       who;     // 0 = A, 1 = B
    logic       we;
    logic [3:0] sel;
    logic [7:0] data;
    logic       exp_en;
    logic       exp_err;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    vec_t       v;
    logic       g_own, g_oth, rv_own;
    logic [7:0] rd_own;
    int         waited;
    logic       found;

    vecs[0]  = '{1'b0, 1'b1, 4'd3,  8'h5A, 1'b1, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 1'b0, 4'd3,  8'h00, 1'b0, 1'b0, 8'h5A};
    vecs[2]  = '{1'b1, 1'b1, 4'd8,  8'hA7, 1'b1, 1'b0, 8'h00};
    vecs[3]  = '{1'b1, 1'b0, 4'd8,  8'h00, 1'b0, 1'b0, 8'hA7};
    vecs[4]  = '{1'b0, 1'b1, 4'd10, 8'h33, 1'b0, 1'b1, 8'h00};
    vecs[5]  = '{1'b0, 1'b0, 4'd10, 8'h00, 1'b0, 1'b1, 8'h00};
    vecs[6]  = '{1'b1, 1'b0, 4'd3,  8'h00, 1'b0, 1'b0, 8'h5A};
    vecs[7]  = '{1'b0, 1'b0, 4'd15, 8'h00, 1'b0, 1'b0, 8'h3C};
    vecs[8]  = '{1'b1, 1'b1, 4'd0,  8'h01, 1'b1, 1'b0, 8'h00};
    vecs[9]  = '{1'b0, 1'b0, 4'd0,  8'h00, 1'b0, 1'b0, 8'h01};
    vecs[10] = '{1'b1, 1'b0, 4'd12, 8'h00, 1'b0, 1'b1, 8'h00};

    // Reset values
    step(); step();
    chk("rst_gnt_a",    32'(gnt_a),    32'h0);
    chk("rst_gnt_b",    32'(gnt_b),    32'h0);
    chk("rst_rvalid_a", 32'(rvalid_a), 32'h0);
    chk("rst_rvalid_b", 32'(rvalid_b), 32'h0);
    chk("rst_rdata_a",  32'(rdata_a),  32'h0);
    chk("rst_rdata_b",  32'(rdata_b),  32'h0);
    chk("rst_rf_en",    32'(rf_en),    32'h0);
    chk("rst_rf_sel",   32'(rf_sel),   32'h0);
    chk("rst_rf_in",    32'(rf_in),    32'h0);
    chk("rst_busy",     32'(busy),     32'h0);
    chk("rst_err",      32'(err),      32'h0);
    mem_init = 1'b0;
    rst = 1'b0;
    step();

    // Single-requester transactions
    for (int i = 0; i < 11; i++) begin
      v = vecs[i];
      if (!v.who) drive_a(1'b1, v.we, v.sel, v.data);
      else        drive_b(1'b1, v.we, v.sel, v.data);
      step();
      g_own = v.who ? gnt_b : gnt_a;
      g_oth = v.who ? gnt_a : gnt_b;
      chk($sformatf("v%0d_gnt", i),     32'(g_own), 32'h1);
      chk($sformatf("v%0d_gnt_oth", i), 32'(g_oth), 32'h0);
      chk($sformatf("v%0d_rf_en", i),   32'(rf_en), 32'(v.exp_en));
      chk($sformatf("v%0d_err", i),     32'(err),   32'(v.exp_err));
      chk($sformatf("v%0d_busy", i),    32'(busy),  32'h1);
      if (v.we) begin
        chk($sformatf("v%0d_rf_sel", i), 32'(rf_sel), 32'(v.sel));
        chk($sformatf("v%0d_rf_in", i),  32'(rf_in),  32'(v.data));
      end
      if (!v.who) drive_a(1'b0, 1'b0, 4'd0, 8'h00);
      else        drive_b(1'b0, 1'b0, 4'd0, 8'h00);
      step();
      g_own  = v.who ? gnt_b : gnt_a;
      rv_own = v.who ? rvalid_b : rvalid_a;
      rd_own = v.who ? rdata_b : rdata_a;
      chk($sformatf("v%0d_gnt_end", i), 32'(g_own), 32'h0);
      chk($sformatf("v%0d_err_end", i), 32'(err),   32'h0);
      chk($sformatf("v%0d_rvalid", i),  32'(rv_own), 32'(!v.we));
      if (!v.we) chk($sformatf("v%0d_rdata", i), 32'(rd_own), 32'(v.exp_rd));
      step();
      rv_own = v.who ? rvalid_b : rvalid_a;
      chk($sformatf("v%0d_rvalid_pulse", i), 32'(rv_own), 32'h0);
      chk($sformatf("v%0d_idle", i),         32'(busy),   32'h0);
    end

    // Reset in the middle of an ACCESS cycle
    drive_a(1'b1, 1'b1, 4'd3, 8'h77);
    step();
    chk("mid_rf_en_before", 32'(rf_en), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rf_en_async", 32'(rf_en), 32'h0);
    chk("mid_busy_async",  32'(busy),  32'h0);
    chk("mid_gnt_async",   32'(gnt_a), 32'h0);
    drive_a(1'b0, 1'b0, 4'd0, 8'h00);
    step(); step(); step();
    rst = 1'b0;
    chk("mid_rdata_a_cleared", 32'(rdata_a), 32'h0);
    for (int k = 0; k < 2; k++) begin
      step();
      chk($sformatf("mid_no_gnt_%0d", k),    32'(gnt_a),    32'h0);
      chk($sformatf("mid_no_rvalid_%0d", k), 32'(rvalid_a), 32'h0);
    end

    // Both requesting and held: A first (pointer reset to A), then alternating
    drive_a(1'b1, 1'b0, 4'd3, 8'h00);
    drive_b(1'b1, 1'b0, 4'd8, 8'h00);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("both_gnt_a_%0d", k), 32'(gnt_a), 32'(k % 2 == 0));
      chk($sformatf("both_gnt_b_%0d", k), 32'(gnt_b), 32'(k % 2 == 1));
      chk($sformatf("both_rf_en_%0d", k), 32'(rf_en), 32'h0);
      if (k > 0) begin
        if (k % 2 == 1) begin
          chk($sformatf("both_rvalid_a_%0d", k), 32'(rvalid_a), 32'h1);
          chk($sformatf("both_rdata_a_%0d", k),  32'(rdata_a),  32'h5A);
        end else begin
          chk($sformatf("both_rvalid_b_%0d", k), 32'(rvalid_b), 32'h1);
          chk($sformatf("both_rdata_b_%0d", k),  32'(rdata_b),  32'hA7);
        end
      end
    end
    drive_a(1'b0, 1'b0, 4'd0, 8'h00);
    drive_b(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk("both_last_rvalid_b", 32'(rvalid_b), 32'h1);
    chk("both_last_rdata_b",  32'(rdata_b),  32'hA7);
    chk("both_end_busy",      32'(busy),     32'h0);
    step();

    // Port write by B with stretch; A raised during HOLD waits for IDLE
    drive_b(1'b1, 1'b1, 4'd15, 8'hC3);
    step();
    chk("port_gnt_b",  32'(gnt_b),  32'h1);
    chk("port_rf_en0", 32'(rf_en),  32'h1);
    chk("port_sel0",   32'(rf_sel), 32'd15);
    chk("port_in0",    32'(rf_in),  32'hC3);
    drive_b(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk("port_rf_en1", 32'(rf_en),  32'h1);
    chk("port_sel1",   32'(rf_sel), 32'd15);
    chk("port_in1",    32'(rf_in),  32'hC3);
    chk("port_gnt1",   32'(gnt_b),  32'h0);
    chk("port_busy1",  32'(busy),   32'h1);
    drive_a(1'b1, 1'b0, 4'd15, 8'h00);
    step();
    chk("port_rf_en2", 32'(rf_en),  32'h1);
    chk("port_sel2",   32'(rf_sel), 32'd15);
    chk("port_gnt_a2", 32'(gnt_a),  32'h0);
    chk("port_busy2",  32'(busy),   32'h1);
    step();
    chk("port_rf_en3", 32'(rf_en),  32'h0);
    chk("port_busy3",  32'(busy),   32'h0);
    chk("port_gnt_a3", 32'(gnt_a),  32'h0);
    step();
    chk("port_gnt_a4", 32'(gnt_a),  32'h1);
    chk("port_rd_en4", 32'(rf_en),  32'h0);
    drive_a(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk("port_rvalid_a", 32'(rvalid_a), 32'h1);
    chk("port_rdata_a",  32'(rdata_a),  32'hC3);
    step();

    // B read while A requests continuously
    drive_a(1'b1, 1'b0, 4'd0, 8'h00);
    step();
    chk("starve_gnt_a0", 32'(gnt_a), 32'h1);
    drive_b(1'b1, 1'b0, 4'd8, 8'h00);
    waited = 0;
    found  = 1'b0;
    for (int k = 0; k < 6 && !found; k++) begin
      step();
      if (gnt_b) found = 1'b1;
      else       waited++;
    end
    chk("starve_b_granted", 32'(found), 32'h1);
    chk("starve_b_wait",    32'(waited), 32'h0);
    chk("starve_gnt_a_off", 32'(gnt_a),  32'h0);
    chk("starve_rvalid_a",  32'(rvalid_a), 32'h1);
    chk("starve_rdata_a",   32'(rdata_a),  32'h01);
    drive_b(1'b0, 1'b0, 4'd0, 8'h00);
    step();
    chk("starve_rvalid_b", 32'(rvalid_b), 32'h1);
    chk("starve_rdata_b",  32'(rdata_b),  32'hA7);
    chk("starve_gnt_a1",   32'(gnt_a),    32'h1);
    drive_a(1'b0, 1'b0, 4'd0, 8'h00);
    step(); step();
    chk("final_idle", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
